reg_universal: RTL

REG_UNIVERSAL -- requirements
Module: reg_universal

---
 rtl/reg_universal_pkg.sv | 24 ++
 rtl/reg_universal_burst_counter.sv | 40 ++++
 rtl/reg_universal.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_universal_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// burst state type and a helper that classifies burst-capable modes.
package reg_universal_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_SHR   = 3'd2;
    localparam logic [2:0] MODE_SHL   = 3'd3;
    localparam logic [2:0] MODE_ROR   = 3'd4;
    localparam logic [2:0] MODE_ROL   = 3'd5;
    localparam logic [2:0] MODE_CLR   = 3'd6;
    localparam logic [2:0] MODE_HOLD7 = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Only the four shift/rotate modes may be repeated as a burst.
    function automatic logic is_burst_mode(input logic [2:0] m);
        return (m >= MODE_SHR) && (m <= MODE_ROL);
    endfunction

endpackage

// File: rtl/reg_universal_burst_counter.sv
// Burst length down-counter: parallel load, decrement when enabled,
// and a flag marking that the next decrement consumes the final shift.
module burst_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; never wrap below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/reg_universal.sv
// Universal shift register with single-cycle operations and a counted
// burst mode that repeats one shift/rotate a programmable number of times.
module reg_universal
    import reg_universal_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             start,
    input  logic [CNT_W-1:0] n_shift,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    state_e           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_last_s;

    // One operation applied to the current register value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             smsb,
        input logic             slsb
    );
        logic [WIDTH-1:0] r;
        case (m)
            MODE_LOAD: r = din;
            MODE_SHR:  r = {smsb, cur[WIDTH-1:1]};
            MODE_SHL:  r = {cur[WIDTH-2:0], slsb};
            MODE_ROR:  r = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_CLR:  r = {WIDTH{1'b0}};
            default:   r = cur;
        endcase
        return r;
    endfunction

    burst_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (n_shift),
        .dec_i      (cnt_dec_s),
        .last_o     (cnt_last_s)
    );

    // Next-state and next-value selection for the register and burst control.
    always_comb begin
        q_d        = q_q;
        state_d    = state_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && is_burst_mode(mode)) begin
                        if (n_shift != {CNT_W{1'b0}}) begin
                            state_d    = ST_BUSY;
                            busy_d     = 1'b1;
                            mode_d     = mode;
                            cnt_load_s = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        q_d = apply_op(mode, q_q, d, sin_msb, sin_lsb);
                    end
                end
                ST_BUSY: begin
                    q_d       = apply_op(mode_q, q_q, d, sin_msb, sin_lsb);
                    cnt_dec_s = 1'b1;
                    if (cnt_last_s) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= {WIDTH{1'b0}};
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q        = q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
